// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the actuated intersection scheduler:
//   - approach encoding (DIR_N..DIR_W), matching bit positions of the req mask
//   - lamp codes driven on each approach's 3-bit lamp bus
//   - phase-state enum used by the scheduler FSM
//   - dir_onehot(): converts an approach index to its req-mask bit
package traffic_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } phase_t;

  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Combinational 4-way round-robin picker.
//   req    [3:0] in  : request mask, bit i = approach i
//   ptr    [1:0] in  : last granted approach; search starts at ptr+1 and wraps
//   winner [1:0] out : first requesting approach in that order (ptr when none)
//   valid        out : at least one request present
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] cand;

  // Walk from the lowest priority (ptr itself) up to the highest (ptr+1);
  // the last hit overwrites earlier ones, so the highest-priority requester wins.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    valid  = |req;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Actuated four-way intersection scheduler. Grants green to one approach at a
// time in round-robin order among requesting approaches, with a yellow and an
// all-red interval between grants. Green is held while no one else waits,
// cut early when the owner's demand goes away, and capped at GREEN_MAX when
// others wait. Emergency pre-emption forces a chosen approach to green.
//   clk            in  : clock
//   rst            in  : synchronous active-high reset
//   req      [3:0] in  : vehicle present, bit0 N, bit1 S, bit2 E, bit3 W
//   emerg          in  : pre-emption request (level)
//   emerg_dir[1:0] in  : pre-empting approach
//   north/south/east/west [2:0] out : lamp codes (001 green, 010 yellow, 100 red)
//   active_dir[1:0] out : approach owning the phase during green/yellow, else 0
//   grant          out : one-cycle pulse in the first green cycle of a grant
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int TW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emerg,
  input  logic [1:0] emerg_dir,
  output logic [2:0] north,
  output logic [2:0] south,
  output logic [2:0] east,
  output logic [2:0] west,
  output logic [1:0] active_dir,
  output logic       grant
);

  localparam logic [TW-1:0] MIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_T - 1);

  phase_t        state_reg, state_next;
  logic [TW-1:0] tmr_reg;
  logic [1:0]    ptr_reg;
  logic [1:0]    cur_reg;
  logic          grant_reg;

  logic [1:0]    rr_winner;
  logic          rr_valid;
  logic [1:0]    green_pick;
  logic          green_entry;
  logic          other_req;
  logic          emerg_cut;
  logic          demand_cut;

  rr_arbiter4 u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Pre-emption overrides round robin and does not need its own req bit.
  assign green_pick = emerg ? emerg_dir : rr_winner;

  assign other_req  = |(req & ~dir_onehot(cur_reg));
  assign emerg_cut  = emerg && (emerg_dir != cur_reg);
  // Demand-driven cut: someone else waits, minimum served, and either the
  // owner has gone away or the maximum has been reached.
  assign demand_cut = !emerg && (tmr_reg >= MIN_LAST) && other_req &&
                      (!req[cur_reg] || (tmr_reg == MAX_LAST));

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (rr_valid || emerg) state_next = ST_GREEN;
      end
      ST_GREEN: begin
        if (emerg_cut || demand_cut) state_next = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (tmr_reg == YEL_LAST) state_next = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (tmr_reg == AR_LAST) begin
          state_next = (rr_valid || emerg) ? ST_GREEN : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign green_entry = (state_next == ST_GREEN) && (state_reg != ST_GREEN);

  // State and phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      tmr_reg   <= '0;
      ptr_reg   <= DIR_W;
      cur_reg   <= DIR_N;
      grant_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= green_entry;
      if (state_next != state_reg) begin
        tmr_reg <= '0;
      end else if (!((state_reg == ST_GREEN) && (tmr_reg == MAX_LAST))) begin
        tmr_reg <= tmr_reg + TW'(1);
      end
      if (green_entry) begin
        cur_reg <= green_pick;
        ptr_reg <= green_pick;
      end
    end
  end

  // Output decode
  logic       owns_phase;
  logic [2:0] owner_lamp;
  logic [2:0] lamp [4];

  always_comb begin
    owns_phase = (state_reg == ST_GREEN) || (state_reg == ST_YELLOW);
    owner_lamp = (state_reg == ST_GREEN)  ? LAMP_GRN :
                 (state_reg == ST_YELLOW) ? LAMP_YEL : LAMP_RED;
    active_dir = owns_phase ? cur_reg : DIR_N;
    grant      = grant_reg;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
    assign lamp[gi] = (cur_reg == 2'(gi)) ? owner_lamp : LAMP_RED;
  end

  assign north = lamp[0];
  assign south = lamp[1];
  assign east  = lamp[2];
  assign west  = lamp[3];

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int GMIN = 4;
  localparam int GMAX = 16;
  localparam int YT   = 3;
  localparam int AT   = 1;
  localparam logic [11:0] ALL_RED = {4{3'b100}};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       emerg;
  logic [1:0] emerg_dir;
  logic [2:0] north, south, east, west;
  logic [1:0] active_dir;
  logic       grant;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase kind (0 idle, 1 green, 2 yellow, 3 all-red),
  // cycles spent in it, current owner and last granted approach.
  int m_mode  = 0;
  int m_age   = 0;
  int m_owner = 0;
  int m_last  = 3;
  bit m_grant = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .TW        (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .emerg      (emerg),
    .emerg_dir  (emerg_dir),
    .north      (north),
    .south      (south),
    .east       (east),
    .west       (west),
    .active_dir (active_dir),
    .grant      (grant)
  );

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int d;
    for (int k = 1; k <= 4; k++) begin
      d = (last + k) % 4;
      if (r[d]) return d;
    end
    return last;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q, input logic e,
                            input logic [1:0] ed);
    bit start;
    bit cut;
    logic [3:0] oth;
    start   = 0;
    m_grant = 0;
    if (r) begin
      m_mode = 0; m_age = 0; m_owner = 0; m_last = 3;
      return;
    end
    case (m_mode)
      0: start = (q != 4'd0) || e;
      1: begin
        oth = q;
        oth[m_owner] = 1'b0;
        if (e) cut = (int'(ed) != m_owner);
        else   cut = (m_age >= GMIN - 1) && (oth != 4'd0) &&
                     (!q[m_owner] || (m_age >= GMAX - 1));
        if (cut) begin m_mode = 2; m_age = 0; end
        else m_age++;
      end
      2: begin
        if (m_age == YT - 1) begin m_mode = 3; m_age = 0; end
        else m_age++;
      end
      default: begin
        if (m_age == AT - 1) begin
          if ((q != 4'd0) || e) start = 1;
          else begin m_mode = 0; m_age = 0; end
        end else m_age++;
      end
    endcase
    if (start) begin
      m_owner = e ? int'(ed) : rr_pick(q, m_last);
      m_last  = m_owner;
      m_mode  = 1;
      m_age   = 0;
      m_grant = 1;
    end
  endtask

  function automatic logic [2:0] exp_lamp(input int d);
    if (m_mode == 1 && m_owner == d) return LAMP_GRN;
    if (m_mode == 2 && m_owner == d) return LAMP_YEL;
    return LAMP_RED;
  endfunction

  function automatic logic [11:0] exp_lamps();
    return {exp_lamp(3), exp_lamp(2), exp_lamp(1), exp_lamp(0)};
  endfunction

  function automatic logic [11:0] dut_lamps();
    return {west, east, south, north};
  endfunction

  // One clock: inputs are already driven; DUT and model both see them at the edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst, req, emerg, emerg_dir);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 4'd0; emerg = 1'b0; emerg_dir = 2'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; emerg = 1'b1; emerg_dir = 2'd2;
    tick();
    tick();
    checks++;
    if (dut_lamps() !== ALL_RED) begin
      failures++;
      $display("FAIL reset_lamps got=%h want=%h", dut_lamps(), ALL_RED);
    end
    checks++;
    if (active_dir !== 2'd0) begin
      failures++;
      $display("FAIL reset_active_dir got=%0d want=0", active_dir);
    end
    checks++;
    if (grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant got=%b want=0", grant);
    end
    rst = 1'b0; req = 4'd0; emerg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_lamps() !== ALL_RED || grant !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d lamps=%h grant=%b want lamps=%h grant=0",
                 i, dut_lamps(), grant, ALL_RED);
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_rest_in_green();
    int grants;
    int yellows;
    apply_reset();
    req = 4'b0001;
    grants = 0;
    yellows = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (north !== LAMP_GRN || grant !== 1'b1) begin
          failures++;
          $display("FAIL rest_first_green north=%b grant=%b want north=001 grant=1", north, grant);
        end
      end
      grants  += int'(grant);
      yellows += int'(north == LAMP_YEL);
      checks++;
      if (dut_lamps() !== exp_lamps()) begin
        failures++;
        $display("FAIL rest_lamps cyc=%0d got=%h want=%h", i, dut_lamps(), exp_lamps());
      end
    end
    checks++;
    if (grants != 1) begin
      failures++;
      $display("FAIL rest_grant_count got=%0d want=1", grants);
    end
    checks++;
    if (yellows != 0) begin
      failures++;
      $display("FAIL rest_yellow_count got=%0d want=0", yellows);
    end
    $display("test_rest_in_green done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_two_way();
    int gpos[$];
    int gdir[$];
    int ngreen;
    int period;
    period = GMAX + YT + AT;
    apply_reset();
    req = 4'b0101;
    ngreen = 0;
    for (int i = 0; i < 2 * period + 5; i++) begin
      tick();
      if (grant === 1'b1) begin
        gpos.push_back(i);
        gdir.push_back(int'(active_dir));
      end
      if (i < period && north == LAMP_GRN) ngreen++;
      checks++;
      if (dut_lamps() !== exp_lamps() || grant !== m_grant) begin
        failures++;
        $display("FAIL two_way cyc=%0d lamps=%h grant=%b want lamps=%h grant=%b",
                 i, dut_lamps(), grant, exp_lamps(), m_grant);
      end
    end
    checks++;
    if (ngreen != GMAX) begin
      failures++;
      $display("FAIL two_way_green_len got=%0d want=%0d", ngreen, GMAX);
    end
    checks++;
    if (gpos.size() != 3) begin
      failures++;
      $display("FAIL two_way_grants got=%0d want=3", gpos.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gpos[k] != k * period || gdir[k] != ((k == 1) ? 2 : 0)) begin
          failures++;
          $display("FAIL two_way_grant%0d at=%0d dir=%0d want at=%0d dir=%0d",
                   k, gpos[k], gdir[k], k * period, (k == 1) ? 2 : 0);
        end
      end
    end
    $display("test_two_way done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_min_green();
    int ngreen;
    int south_at;
    apply_reset();
    req = 4'b0011;
    tick();
    ngreen = int'(north == LAMP_GRN);
    south_at = -1;
    req = 4'b0010;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (north == LAMP_GRN) ngreen++;
      if (south == LAMP_GRN && grant === 1'b1 && south_at < 0) south_at = i;
      checks++;
      if (dut_lamps() !== exp_lamps()) begin
        failures++;
        $display("FAIL min_green_lamps cyc=%0d got=%h want=%h", i, dut_lamps(), exp_lamps());
      end
    end
    checks++;
    if (ngreen != GMIN) begin
      failures++;
      $display("FAIL min_green_len got=%0d want=%0d", ngreen, GMIN);
    end
    checks++;
    if (south_at != GMIN + YT + AT) begin
      failures++;
      $display("FAIL min_green_south_grant got=%0d want=%0d", south_at, GMIN + YT + AT);
    end
    $display("test_min_green done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_emergency();
    int nyel;
    int west_at;
    int west_lost;
    apply_reset();
    req = 4'b0100;
    tick();
    tick();
    checks++;
    if (east !== LAMP_GRN) begin
      failures++;
      $display("FAIL emerg_east_green got=%b want=001", east);
    end
    emerg = 1'b1; emerg_dir = 2'd3; req = 4'b1111;
    nyel = 0; west_at = -1; west_lost = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (east !== LAMP_YEL) begin
          failures++;
          $display("FAIL emerg_cut east=%b want=010", east);
        end
      end
      if (east == LAMP_YEL) nyel++;
      if (west == LAMP_GRN && west_at < 0) west_at = i;
      if (west_at >= 0 && west != LAMP_GRN) west_lost++;
      checks++;
      if (dut_lamps() !== exp_lamps() || grant !== m_grant) begin
        failures++;
        $display("FAIL emerg_lamps cyc=%0d lamps=%h grant=%b want lamps=%h grant=%b",
                 i, dut_lamps(), grant, exp_lamps(), m_grant);
      end
    end
    checks++;
    if (nyel != YT) begin
      failures++;
      $display("FAIL emerg_yellow_len got=%0d want=%0d", nyel, YT);
    end
    checks++;
    if (west_at != YT + AT) begin
      failures++;
      $display("FAIL emerg_west_start got=%0d want=%0d", west_at, YT + AT);
    end
    checks++;
    if (west_lost != 0) begin
      failures++;
      $display("FAIL emerg_west_hold lost=%0d want=0", west_lost);
    end
    emerg = 1'b0;
    $display("test_emergency done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid_yellow();
    apply_reset();
    req = 4'b0001;
    tick();
    emerg = 1'b1; emerg_dir = 2'd1;
    tick();
    emerg = 1'b0; req = 4'd0;
    tick();
    checks++;
    if (north !== LAMP_YEL) begin
      failures++;
      $display("FAIL midrst_second_yellow north=%b want=010", north);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dut_lamps() !== ALL_RED || active_dir !== 2'd0 || grant !== 1'b0) begin
      failures++;
      $display("FAIL midrst_all_red lamps=%h dir=%0d grant=%b want lamps=%h dir=0 grant=0",
               dut_lamps(), active_dir, grant, ALL_RED);
    end
    tick();
    rst = 1'b0; req = 4'b1000;
    tick();
    checks++;
    if (west !== LAMP_GRN || grant !== 1'b1 || active_dir !== 2'd3) begin
      failures++;
      $display("FAIL midrst_west_first west=%b grant=%b dir=%0d want west=001 grant=1 dir=3",
               west, grant, active_dir);
    end
    $display("test_reset_mid_yellow done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int nonred;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if (emerg) begin
        if ($urandom_range(0, 9) == 0) emerg = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        emerg = 1'b1;
        emerg_dir = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (dut_lamps() !== exp_lamps() || grant !== m_grant) begin
        failures++;
        $display("FAIL random_lamps cyc=%0d lamps=%h grant=%b want lamps=%h grant=%b",
                 n, dut_lamps(), grant, exp_lamps(), m_grant);
      end
      if (m_mode == 1 || m_mode == 2) begin
        checks++;
        if (active_dir !== 2'(m_owner)) begin
          failures++;
          $display("FAIL random_active_dir cyc=%0d got=%0d want=%0d", n, active_dir, m_owner);
        end
      end
      nonred = int'(north != LAMP_RED) + int'(south != LAMP_RED) +
               int'(east != LAMP_RED) + int'(west != LAMP_RED);
      checks++;
      if (nonred > 1) begin
        failures++;
        $display("FAIL random_exclusive cyc=%0d nonred=%0d want<=1", n, nonred);
      end
    end
    rst = 1'b0; emerg = 1'b0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; emerg = 1'b0; emerg_dir = 2'd0;
    test_reset();
    test_rest_in_green();
    test_two_way();
    test_min_green();
    test_emergency();
    test_reset_mid_yellow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Actuated four-way intersection scheduler. It grants green to one approach at a time, in round-robin order among approaches with a vehicle request, and inserts a yellow interval and an all-red interval between grants. Green is stretched or cut according to sensor demand, within minimum and maximum limits. An emergency pre-emption input forces a chosen approach to green. It drives the same per-approach 3-bit lamp buses as the fixed-time light controller and replaces it at sensor-equipped junctions.

## Interface
- `GREEN_MIN`, 4: minimum green length in cycles, ≥1.
- `GREEN_MAX`, 16: maximum green length in cycles when another approach is waiting, > `GREEN_MIN`.
- `YELLOW_T`, 3: yellow length in cycles, ≥1.
- `ALLRED_T`, 1: all-red clearance length in cycles, ≥1.
- `TW`, 5: phase timer width; must hold `GREEN_MAX-1`.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: vehicle-present levels. Bit 0 north, bit 1 south, bit 2 east, bit 3 west.
- `emerg` in 1: pre-emption request, level.
- `emerg_dir` in 2: pre-empting approach. 0 north, 1 south, 2 east, 3 west. Sampled while `emerg` is high.
- `north`, `south`, `east`, `west` out 3: lamp codes. 3'b001 green, 3'b010 yellow, 3'b100 red.
- `active_dir` out 2: approach currently owning the phase (green or yellow).
- `grant` out 1: one-cycle pulse in the first green cycle of each grant.

## Operation
- FSM states: IDLE (all red, nothing pending), GREEN, YELLOW, ALLRED.
- Phase timer `tmr` clears on every state entry and increments each cycle.
  - In GREEN it saturates at `GREEN_MAX-1`.
- Round-robin pointer `ptr` holds the last granted approach.
  - Winner = first set bit of the request mask, searching from `ptr+1` and wrapping.
  - `ptr` updates to the winner on every GREEN entry.
- Choosing the approach at GREEN entry:
  - If `emerg` is high, the emergency approach is `emerg_dir`, whether or not its `req` bit is set.
  - Otherwise the round-robin winner of `req` is granted.
- IDLE: if `req` is non-zero or `emerg` is high, go to GREEN; otherwise stay in IDLE.
- GREEN (approach `cur`) goes to YELLOW when any of these holds:
  - `emerg` is high and `emerg_dir` ≠ `cur`. This ignores `GREEN_MIN`.
  - `emerg` is low, `tmr` ≥ `GREEN_MIN-1`, some other `req` bit is set, and either `req[cur]`=0 or `tmr`=`GREEN_MAX-1`.
- GREEN holds indefinitely in these cases:
  - No other approach is requesting, even if `req[cur]` is 0 (rest-in-green).
  - `emerg` is high with `emerg_dir` = `cur`.
- YELLOW always lasts exactly `YELLOW_T` cycles, then goes to ALLRED. Emergency does not shorten it.
- ALLRED lasts exactly `ALLRED_T` cycles. Then:
  - GREEN if `emerg` is high or `req` is non-zero.
  - IDLE otherwise.
  - In ALLRED the previous `cur` is eligible again, but only after the other approaches in round-robin order.
- Lamps:
  - `cur` shows green in GREEN and yellow in YELLOW.
  - Every other approach shows red at all times.
  - All four show red in IDLE and ALLRED.
- At most one lamp bus is non-red in any cycle. Verification asserts this.

## Timing
- State, `tmr`, `ptr`, `cur` and `grant` are registered. Lamp buses and `active_dir` are decoded combinationally from the registered state and `cur`.
- Reset values, one cycle after `rst` is sampled high:
  - State IDLE.
  - All lamps 3'b100.
  - `active_dir` = 0, `grant` = 0, `tmr` = 0.
  - `ptr` = 3, so north has first priority.
- `rst` asserted mid-phase (GREEN/YELLOW/ALLRED) forces all-red on the next cycle. It overrides `emerg`.
- IDLE → GREEN latency: a request sampled high at edge k gives green and `grant` from edge k.
- A green cut at timer value t lasts t+1 cycles:
  - `GREEN_MIN` cycles minimum when an opposing request exists.
  - `GREEN_MAX` cycles maximum when the own request persists.
- Cycles from the last green to the next green = `YELLOW_T + ALLRED_T` (4 with defaults).
- `req` and `emerg` are used as sampled at each edge. The block does not synchronize or debounce them; the upstream sensor block does.

## Structure
- Shared package `traffic_pkg` holds:
  - Direction encoding (`DIR_N`..`DIR_W`).
  - Lamp constants `LAMP_RED`, `LAMP_YEL`, `LAMP_GRN`.
  - The phase-state enum.
- Sub-module `rr_arbiter4`: combinational 4-way round-robin picker.
  - Inputs: request mask and pointer.
  - Outputs: winner index and a valid flag.

## Test plan
- Reset: hold `rst` for 2 cycles → all lamps 3'b100, `active_dir`=0, `grant`=0. Release with `req`=0 → stays IDLE.
- `req`=4'b0001 held → north 3'b001 starting at the sampling edge, one `grant` pulse, no yellow for 50 cycles.
- `req`=4'b0101 held → phases north → east → north, each 16 green + 3 yellow + 1 all-red, `grant` every 20 cycles.
- North green with `req`=4'b0011, north drops after 1 cycle → exactly 4 green cycles, then south after 3 yellow + 1 all-red.
- East green at `tmr`=1, `emerg`=1 with `emerg_dir`=3 → yellow next cycle, 3 yellow + 1 all-red, then west green held while `emerg` stays high with `req`=4'b1111.
- `rst` in the second yellow cycle → all red next cycle. After release with `req`=4'b1000, west green first.
